fetch_pc_gen: RTL and testbench

Fetch-stage PC generator and single-entry fetch buffer. It sits directly downstream of the BTB: it presents the current fetch PC for BTB lookup and folds the returned prediction into the next PC. It also issues one-at-a-time I-cache requests, applies execute-stage redirects, and discards stale responses. It delivers a registered instruction packet, carrying its predicted next PC, to decode.

---
 rtl/fetch_pc_gen.sv | 181 ++++++++++++++++++
 tb/tb_fetch_pc_gen.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
// Fetch-stage PC generator with a single-entry fetch buffer. It presents the
// current fetch PC to the BTB, folds the same-cycle prediction into the next
// PC, issues one I-cache request at a time, applies execute-stage redirects,
// discards stale responses and hands a registered packet to decode.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   btb_lookup_pc           current fetch PC to the BTB (combinational)
//   btb_valid/taken/target  same-cycle BTB prediction for btb_lookup_pc
//   redirect_valid/pc       mispredict correction from execute
//   icache_req_*            request handshake (valid/ready, address)
//   icache_rsp_*            instruction response
//   id_*                    registered packet to decode
//   id_stall                decode cannot accept; packet holds
// -----------------------------------------------------------------------------
module fetch_pc_gen #(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] btb_lookup_pc,
  input  logic            btb_valid,
  input  logic            btb_taken,
  input  logic [XLEN-1:0] btb_target,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            icache_req_valid,
  output logic [XLEN-1:0] icache_req_pc,
  input  logic            icache_req_ready,
  input  logic            icache_rsp_valid,
  input  logic [XLEN-1:0] icache_rsp_inst,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_npc,
  output logic            id_pred_taken,
  input  logic            id_stall
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic [XLEN-1:0] inflight_npc_q, inflight_npc_d;
  logic            inflight_taken_q, inflight_taken_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_inst_q, id_inst_d;
  logic [XLEN-1:0] id_npc_q, id_npc_d;
  logic            id_taken_q, id_taken_d;

  logic            slot_free_s;
  logic            req_valid_s;
  logic            accept_s;
  logic            pred_s;
  logic [XLEN-1:0] npc_s;

  // Request gating, BTB fold-in and next-PC arithmetic (wraps mod 2^XLEN).
  always_comb begin
    slot_free_s = !id_valid_q || !id_stall;
    req_valid_s = (state_q == ST_REQ) && slot_free_s && !reset;
    accept_s    = req_valid_s && icache_req_ready;
    pred_s      = btb_valid && btb_taken;
    if (pred_s) begin
      npc_s = btb_target;
    end else begin
      npc_s = fetch_pc_q + XLEN'(3'd4);
    end
  end

  // Next-state logic; a redirect overrides every normal transition.
  always_comb begin
    state_d          = state_q;
    fetch_pc_d       = fetch_pc_q;
    inflight_pc_d    = inflight_pc_q;
    inflight_npc_d   = inflight_npc_q;
    inflight_taken_d = inflight_taken_q;
    id_pc_d          = id_pc_q;
    id_inst_d        = id_inst_q;
    id_npc_d         = id_npc_q;
    id_taken_d       = id_taken_q;
    // Consume clears the slot unless a load below refills it.
    if (id_valid_q && !id_stall) begin
      id_valid_d = 1'b0;
    end else begin
      id_valid_d = id_valid_q;
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      id_valid_d = 1'b0;
      case (state_q)
        // A request accepted alongside the redirect is already stale.
        ST_REQ:   state_d = accept_s ? ST_DRAIN : ST_REQ;
        ST_WAIT:  state_d = icache_rsp_valid ? ST_REQ : ST_DRAIN;
        ST_DRAIN: state_d = icache_rsp_valid ? ST_REQ : ST_DRAIN;
        default:  state_d = ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          if (accept_s) begin
            inflight_pc_d    = fetch_pc_q;
            inflight_npc_d   = npc_s;
            inflight_taken_d = pred_s;
            fetch_pc_d       = npc_s;
            state_d          = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_WAIT: begin
          // The slot is guaranteed empty here because REQ waited for it.
          if (icache_rsp_valid) begin
            id_valid_d = 1'b1;
            id_pc_d    = inflight_pc_q;
            id_inst_d  = icache_rsp_inst;
            id_npc_d   = inflight_npc_q;
            id_taken_d = inflight_taken_q;
            state_d    = ST_REQ;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_DRAIN: begin
          if (icache_rsp_valid) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  // State and packet registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= ST_REQ;
      fetch_pc_q       <= RESET_PC;
      inflight_pc_q    <= '0;
      inflight_npc_q   <= '0;
      inflight_taken_q <= 1'b0;
      id_valid_q       <= 1'b0;
      id_pc_q          <= '0;
      id_inst_q        <= '0;
      id_npc_q         <= '0;
      id_taken_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      fetch_pc_q       <= fetch_pc_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_npc_q   <= inflight_npc_d;
      inflight_taken_q <= inflight_taken_d;
      id_valid_q       <= id_valid_d;
      id_pc_q          <= id_pc_d;
      id_inst_q        <= id_inst_d;
      id_npc_q         <= id_npc_d;
      id_taken_q       <= id_taken_d;
    end
  end

  assign btb_lookup_pc    = fetch_pc_q;
  assign icache_req_valid = req_valid_s;
  assign icache_req_pc    = fetch_pc_q;
  assign id_valid         = id_valid_q;
  assign id_pc            = id_pc_q;
  assign id_inst          = id_inst_q;
  assign id_npc           = id_npc_q;
  assign id_pred_taken    = id_taken_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_gen
// Self-checking bench for fetch_pc_gen. A table of fetches drives the main
// path; expected packets are queued when a request is accepted and popped
// when decode sees a packet. Hand-written sequences cover stall, redirect and
// wrap-around corners. A second instance uses RESET_PC = 0xFFFFFFFC.
// -----------------------------------------------------------------------------
module tb_fetch_pc_gen;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  // Instance 0 (RESET_PC = 0)
  logic        reset, btb_valid, btb_taken, redirect_valid;
  logic [31:0] btb_target, redirect_pc, icache_rsp_inst;
  logic        icache_req_ready, icache_rsp_valid, id_stall;
  logic [31:0] btb_lookup_pc, icache_req_pc, id_pc, id_inst, id_npc;
  logic        icache_req_valid, id_valid, id_pred_taken;

  // Instance 1 (RESET_PC = 0xFFFFFFFC)
  logic        reset1, ready1, rspv1;
  logic [31:0] rspi1;
  logic [31:0] lookup1, req_pc1, id_pc1, id_inst1, id_npc1;
  logic        req_valid1, id_valid1, id_taken1;

  fetch_pc_gen #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset),
    .btb_lookup_pc(btb_lookup_pc), .btb_valid(btb_valid),
    .btb_taken(btb_taken), .btb_target(btb_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .icache_req_valid(icache_req_valid), .icache_req_pc(icache_req_pc),
    .icache_req_ready(icache_req_ready), .icache_rsp_valid(icache_rsp_valid),
    .icache_rsp_inst(icache_rsp_inst), .id_valid(id_valid), .id_pc(id_pc),
    .id_inst(id_inst), .id_npc(id_npc), .id_pred_taken(id_pred_taken),
    .id_stall(id_stall)
  );

  fetch_pc_gen #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clock(clock), .reset(reset1),
    .btb_lookup_pc(lookup1), .btb_valid(1'b0),
    .btb_taken(1'b0), .btb_target(32'h0000_0000),
    .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
    .icache_req_valid(req_valid1), .icache_req_pc(req_pc1),
    .icache_req_ready(ready1), .icache_rsp_valid(rspv1),
    .icache_rsp_inst(rspi1), .id_valid(id_valid1), .id_pc(id_pc1),
    .id_inst(id_inst1), .id_npc(id_npc1), .id_pred_taken(id_taken1),
    .id_stall(1'b0)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] npc;
    logic        taken;
  } pkt_t;

  typedef struct {
    logic        bv;
    logic        bt;
    logic [31:0] tgt;
    logic [31:0] inst;
    logic [31:0] exp_pc;
    logic [31:0] exp_npc;
    logic        exp_taken;
  } vec_t;

  pkt_t sb[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Wait (bounded) for a request, accept it, queue the expected packet.
  task automatic issue(input logic bv, input logic bt, input logic [31:0] tgt,
                       input logic [31:0] inst, input logic [31:0] exp_pc,
                       input logic [31:0] exp_npc, input logic exp_taken);
    int n;
    n = 0;
    btb_valid = bv; btb_taken = bt; btb_target = tgt;
    icache_req_ready = 1'b1;
    #1;
    while (!icache_req_valid && n < 20) begin
      tick();
      n++;
    end
    if (!icache_req_valid) begin
      checks++; errors++;
      $display("FAIL req_timeout: got no request expected pc %h", exp_pc);
      icache_req_ready = 1'b0;
      return;
    end
    chk("req_pc", icache_req_pc, exp_pc);
    chk("lookup_pc", btb_lookup_pc, exp_pc);
    sb.push_back('{pc: exp_pc, inst: inst, npc: exp_npc, taken: exp_taken});
    tick();
    icache_req_ready = 1'b0; btb_valid = 1'b0; btb_taken = 1'b0;
    #1;
    chk("wait_no_req", {31'd0, icache_req_valid}, 32'd0);
    chk("lookup_after_accept", btb_lookup_pc, exp_npc);
  endtask

  task automatic respond(input logic [31:0] inst);
    icache_rsp_valid = 1'b1; icache_rsp_inst = inst;
    tick();
    icache_rsp_valid = 1'b0;
    #1;
  endtask

  task automatic check_pkt(output pkt_t p);
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_empty: got packet pc %h expected none", id_pc);
      p = '0;
      return;
    end
    p = sb.pop_front();
    chk("id_valid", {31'd0, id_valid}, 32'd1);
    chk("id_pc", id_pc, p.pc);
    chk("id_inst", id_inst, p.inst);
    chk("id_npc", id_npc, p.npc);
    chk("id_pred_taken", {31'd0, id_pred_taken}, {31'd0, p.taken});
  endtask

  initial begin
    pkt_t p;
    pkt_t drop;

    vecs[0] = '{1'b0, 1'b0, 32'h0,  32'hA000_0000, 32'h00, 32'h04, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'h0,  32'hA000_0004, 32'h04, 32'h08, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h40, 32'hA000_0008, 32'h08, 32'h40, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'h80, 32'hA000_0040, 32'h40, 32'h44, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h0,  32'hA000_0044, 32'h44, 32'h48, 1'b0};

    reset = 1'b1; reset1 = 1'b1;
    btb_valid = 1'b0; btb_taken = 1'b0; btb_target = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    icache_req_ready = 1'b0; icache_rsp_valid = 1'b0; icache_rsp_inst = 32'd0;
    id_stall = 1'b0;
    ready1 = 1'b0; rspv1 = 1'b0; rspi1 = 32'd0;

    // Reset state
    tick();
    icache_req_ready = 1'b1;
    #1;
    chk("req_in_reset", {31'd0, icache_req_valid}, 32'd0);
    tick();
    reset = 1'b0;
    icache_req_ready = 1'b0;
    #1;
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_inst", id_inst, 32'd0);
    chk("rst_id_npc", id_npc, 32'd0);
    chk("rst_id_taken", {31'd0, id_pred_taken}, 32'd0);
    chk("rst_req_valid", {31'd0, icache_req_valid}, 32'd1);
    chk("rst_req_pc", icache_req_pc, 32'd0);

    // Table-driven sequential and BTB-predicted fetches
    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].bv, vecs[i].bt, vecs[i].tgt, vecs[i].inst,
            vecs[i].exp_pc, vecs[i].exp_npc, vecs[i].exp_taken);
      respond(vecs[i].inst);
      check_pkt(p);
    end

    // Stall: packet and outputs hold, no request while the slot is full
    issue(1'b0, 1'b0, 32'd0, 32'hB000_0048, 32'h48, 32'h4C, 1'b0);
    id_stall = 1'b1;
    respond(32'hB000_0048);
    check_pkt(p);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'd0, id_valid}, 32'd1);
      chk("stall_pc", id_pc, p.pc);
      chk("stall_inst", id_inst, p.inst);
      chk("stall_npc", id_npc, p.npc);
      chk("stall_no_req", {31'd0, icache_req_valid}, 32'd0);
    end
    id_stall = 1'b0;
    #1;
    chk("unstall_req", {31'd0, icache_req_valid}, 32'd1);
    chk("unstall_req_pc", icache_req_pc, 32'h4C);
    tick();
    chk("consumed", {31'd0, id_valid}, 32'd0);

    // Redirect in WAIT, late response discarded via DRAIN
    issue(1'b0, 1'b0, 32'd0, 32'hC000_004C, 32'h4C, 32'h50, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    #1;
    drop = sb.pop_back();
    chk("redir_id_valid", {31'd0, id_valid}, 32'd0);
    chk("redir_drain_no_req", {31'd0, icache_req_valid}, 32'd0);
    chk("redir_lookup", btb_lookup_pc, 32'h100);
    tick();
    respond(32'hDEAD_BEEF);
    chk("drain_discard", {31'd0, id_valid}, 32'd0);
    chk("drain_exit_req", {31'd0, icache_req_valid}, 32'd1);
    chk("drain_exit_pc", icache_req_pc, 32'h100);
    issue(1'b0, 1'b0, 32'd0, 32'hC000_0100, 32'h100, 32'h104, 1'b0);
    respond(32'hC000_0100);
    check_pkt(p);

    // Redirect coinciding with a response in WAIT: no DRAIN
    issue(1'b0, 1'b0, 32'd0, 32'hC000_0104, 32'h104, 32'h108, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    icache_rsp_valid = 1'b1; icache_rsp_inst = 32'hC000_0104;
    tick();
    redirect_valid = 1'b0; icache_rsp_valid = 1'b0;
    #1;
    drop = sb.pop_back();
    chk("redir_rsp_dropped", {31'd0, id_valid}, 32'd0);
    chk("redir_rsp_req", {31'd0, icache_req_valid}, 32'd1);
    chk("redir_rsp_pc", icache_req_pc, 32'h200);

    // Redirect coinciding with accept: DRAIN, one discard, then redirect PC
    icache_req_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    icache_req_ready = 1'b0; redirect_valid = 1'b0;
    #1;
    chk("acc_redir_no_req", {31'd0, icache_req_valid}, 32'd0);
    chk("acc_redir_lookup", btb_lookup_pc, 32'h300);
    tick();
    chk("acc_redir_still_drain", {31'd0, icache_req_valid}, 32'd0);
    respond(32'hBAD0_0200);
    chk("acc_redir_discard", {31'd0, id_valid}, 32'd0);
    chk("acc_redir_req", {31'd0, icache_req_valid}, 32'd1);
    chk("acc_redir_pc", icache_req_pc, 32'h300);
    issue(1'b1, 1'b1, 32'h10, 32'hD000_0300, 32'h300, 32'h10, 1'b1);
    respond(32'hD000_0300);
    check_pkt(p);
    chk("sb_drained", sb.size(), 32'd0);

    // Wrap-around instance and reset mid-WAIT
    tick();
    reset1 = 1'b0;
    #1;
    chk("wrap_req_valid", {31'd0, req_valid1}, 32'd1);
    chk("wrap_req_pc", req_pc1, 32'hFFFF_FFFC);
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    #1;
    chk("wrap_lookup", lookup1, 32'h0);
    rspv1 = 1'b1; rspi1 = 32'h0000_0077;
    tick();
    rspv1 = 1'b0;
    #1;
    chk("wrap_id_valid", {31'd0, id_valid1}, 32'd1);
    chk("wrap_id_pc", id_pc1, 32'hFFFF_FFFC);
    chk("wrap_id_inst", id_inst1, 32'h0000_0077);
    chk("wrap_id_npc", id_npc1, 32'h0);
    chk("wrap_id_taken", {31'd0, id_taken1}, 32'd0);
    chk("wrap_next_pc", req_pc1, 32'h0);
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    #1;
    chk("wrap_wait_no_req", {31'd0, req_valid1}, 32'd0);
    reset1 = 1'b1;
    tick();
    chk("wrap_req_in_reset", {31'd0, req_valid1}, 32'd0);
    reset1 = 1'b0;
    #1;
    chk("wrap_rst_req", {31'd0, req_valid1}, 32'd1);
    chk("wrap_rst_pc", req_pc1, 32'hFFFF_FFFC);
    chk("wrap_rst_id_valid", {31'd0, id_valid1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
